// File: rtl/icp_mem_pkg.sv
// Shared types and default sizes for the icp local memory.
package icp_mem_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 4096;
    localparam int unsigned CNT_W_DEF  = 13;

    // Lifecycle of one load / run / dump session.
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/icp_mem_ram.sv
// Single-port-write RAM with one registered, read-first read port.
// The read register can be cleared so callers can force a zero result.
module icp_mem_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned AW     = 12
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic              i_clr,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array write; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Read register sees the pre-write contents, holds when not enabled.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/icp_mem.sv
// Local memory for the icp core: host preload, core run control, and
// streamed dump of the final image. One RAM read port is shared between
// core reads (RUN) and dump reads (DUMP); the RAM read register doubles
// as the dump prefetch register, so dump reads are only issued when the
// output slot is free or being consumed.
module icp_mem
    import icp_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_core_rst,
    input  logic              i_core_read_en,
    input  logic [ADDR_W-1:0] i_core_read_addr,
    output logic [DATA_W-1:0] o_core_data,
    input  logic              i_core_write_en,
    input  logic [ADDR_W-1:0] i_core_write_addr,
    input  logic [DATA_W-1:0] i_core_data,
    input  logic              i_load_valid,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_load_last,
    output logic              o_load_ready,
    input  logic              i_stop,
    output logic              o_dump_valid,
    output logic [DATA_W-1:0] o_dump_data,
    output logic              o_dump_last,
    input  logic              i_dump_ready,
    output logic              o_done,
    output logic              o_fault
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             core_rst_q, core_rst_d;
    logic             load_ready_q, load_ready_d;
    logic             dump_valid_q, dump_valid_d;
    logic             dump_last_q, dump_last_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;

    logic              ram_we, ram_re, ram_clr;
    logic [AW-1:0]     ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    logic rd_oob, wr_oob, load_acc, dump_adv;

    // Any set bit above the array index means the access misses the memory.
    assign rd_oob   = |i_core_read_addr[ADDR_W-1:AW];
    assign wr_oob   = |i_core_write_addr[ADDR_W-1:AW];
    assign load_acc = i_load_valid & load_ready_q;
    assign dump_adv = ~dump_valid_q | i_dump_ready;

    // Next-state, RAM port muxing and output updates.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        len_d        = len_q;
        core_rst_d   = core_rst_q;
        load_ready_d = load_ready_q;
        dump_valid_d = dump_valid_q;
        dump_last_d  = dump_last_q;
        done_d       = done_q;
        fault_d      = fault_q;
        ram_we       = 1'b0;
        ram_waddr    = ptr_q[AW-1:0];
        ram_wdata    = i_load_data;
        ram_re       = 1'b0;
        ram_raddr    = ptr_q[AW-1:0];
        ram_clr      = i_rst;

        unique case (state_q)
            ST_LOAD: begin
                load_ready_d = 1'b1;
                if (load_acc) begin
                    ram_we = 1'b1;
                    ptr_d  = ptr_q + CNT_W'(1);
                    // A full array ends the load even without a last marker.
                    if (i_load_last || (ptr_q == CNT_W'(DEPTH - 1))) begin
                        len_d        = ptr_q + CNT_W'(1);
                        ptr_d        = '0;
                        state_d      = ST_RUN;
                        core_rst_d   = 1'b0;
                        load_ready_d = 1'b0;
                    end
                end
            end

            ST_RUN: begin
                ram_re    = i_core_read_en;
                ram_raddr = i_core_read_addr[AW-1:0];
                ram_clr   = i_rst | (i_core_read_en & rd_oob);
                ram_we    = i_core_write_en & ~wr_oob;
                ram_waddr = i_core_write_addr[AW-1:0];
                ram_wdata = i_core_data;
                if ((i_core_read_en & rd_oob) | (i_core_write_en & wr_oob)) begin
                    fault_d = 1'b1;
                end
                if (i_stop) begin
                    state_d    = ST_DUMP;
                    core_rst_d = 1'b1;
                end
            end

            ST_DUMP: begin
                if (dump_valid_q && i_dump_ready && dump_last_q) begin
                    state_d      = ST_DONE;
                    dump_valid_d = 1'b0;
                    dump_last_d  = 1'b0;
                    done_d       = 1'b1;
                end else if (dump_adv) begin
                    if (ptr_q < len_q) begin
                        ram_re       = 1'b1;
                        ptr_d        = ptr_q + CNT_W'(1);
                        dump_valid_d = 1'b1;
                        dump_last_d  = (ptr_q == (len_q - CNT_W'(1)));
                    end else begin
                        dump_valid_d = 1'b0;
                    end
                end
            end

            ST_DONE: begin
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_LOAD;
            ptr_q        <= '0;
            len_q        <= '0;
            core_rst_q   <= 1'b1;
            load_ready_q <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            len_q        <= len_d;
            core_rst_q   <= core_rst_d;
            load_ready_q <= load_ready_d;
            dump_valid_q <= dump_valid_d;
            dump_last_q  <= dump_last_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
        end
    end

    icp_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_waddr (ram_waddr),
        .i_wdata (ram_wdata),
        .i_re    (ram_re),
        .i_clr   (ram_clr),
        .i_raddr (ram_raddr),
        .o_rdata (ram_rdata)
    );

    assign o_core_rst   = core_rst_q;
    assign o_load_ready = load_ready_q;
    assign o_core_data  = ram_rdata;
    assign o_dump_valid = dump_valid_q;
    assign o_dump_data  = ram_rdata;
    assign o_dump_last  = dump_last_q;
    assign o_done       = done_q;
    assign o_fault      = fault_q;

endmodule

// File: doc/icp_mem.md
Name: icp_mem

Overview:
- Word-addressed local memory that sits directly downstream of the icp core. It services the core's read and write ports.
- A host side uses it to preload the program image, release the core, stop it, and stream the final memory image back out.
- It owns the core's run/hold control, so the host sequences a complete load, run and dump without touching the core itself.

Parameters:
DATA_W, 32, word width of the core and host data paths
ADDR_W, 32, width of core address ports
DEPTH, 4096, number of words in the memory (power of two)
CNT_W, 13, width of the length counter; must satisfy 2^CNT_W > DEPTH

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
o_core_rst  out  1  hold/reset to icp; high except in RUN
i_core_read_en  in  1  core read strobe
i_core_read_addr  in  ADDR_W  core read word address
o_core_data  out  DATA_W  read data, valid 1 cycle after strobe
i_core_write_en  in  1  core write strobe
i_core_write_addr  in  ADDR_W  core write word address
i_core_data  in  DATA_W  core write data
i_load_valid  in  1  host load word valid
i_load_data  in  DATA_W  host load word
i_load_last  in  1  marks final load word
o_load_ready  out  1  load word accepted when valid & ready
i_stop  in  1  host request to halt core and dump
o_dump_valid  out  1  dump word valid
o_dump_data  out  DATA_W  dump word
o_dump_last  out  1  qualifies final dump word
i_dump_ready  in  1  host accepts dump word
o_done  out  1  dump complete; sticky until reset
o_fault  out  1  sticky: core accessed an address >= DEPTH

Behaviour:
- Reset values:
  - State is LOAD; the load pointer and length are 0.
  - o_core_rst=1, o_load_ready=0, o_core_data=0.
  - o_dump_valid=0, o_dump_data=0, o_dump_last=0, o_done=0, o_fault=0.
- Reset applies mid-operation from any state. Memory contents are not cleared by reset.
- FSM states: LOAD -> RUN -> DUMP -> DONE. DONE is left only by reset.
- LOAD:
  - o_load_ready is 1 from the first cycle after reset.
  - Each accepted word is written at the load pointer, and the pointer increments.
  - Acceptance with i_load_last=1 ends the load: length = pointer+1, go to RUN.
  - Acceptance at pointer DEPTH-1 is treated as last regardless of i_load_last.
  - i_stop is ignored in LOAD.
- RUN:
  - o_core_rst deasserts on the first cycle in RUN; it is registered, so it is low the cycle after the final load handshake. o_load_ready=0.
  - Core read: if i_core_read_en, the next cycle o_core_data = mem[addr]. With no read strobe, o_core_data holds its value.
  - Core write: if i_core_write_en, mem[addr] = data at the clock edge.
  - Read and write to the same address in the same cycle: read-first, so the old data is returned.
  - Core address >= DEPTH:
    - A write is dropped.
    - A read returns 0.
    - Either sets o_fault.
    - Only address bits above log2(DEPTH) are compared; there is no aliasing.
  - i_stop=1: go to DUMP and raise o_core_rst the next cycle. Core strobes in the cycle i_stop is sampled are still honoured.
- DUMP:
  - Streams mem[0..length-1] in order. o_dump_last=1 on word length-1.
  - Core strobes are ignored; o_core_rst=1.
  - Memory read latency is 1. A one-entry prefetch/skid register hides this.
  - When i_dump_ready is held high, throughput is one word per cycle after a 1-cycle startup bubble.
  - When i_dump_ready=0 with o_dump_valid=1, o_dump_data and o_dump_last stay stable.
  - The handshake on the last word goes to DONE.
- DONE: o_done=1, o_dump_valid=0, o_core_rst=1. All inputs are ignored.
- Length is stored in CNT_W bits. A length of DEPTH is legal.
- The memory is inferred as a single write port with two read paths (core, dump). Core and dump never access it in the same cycle, so the implementation may share one read port.

Decomposition:
- Shared package icp_mem_pkg:
  - state enum {LOAD, RUN, DUMP, DONE}
  - default DEPTH and DATA_W constants
- One sub-module, icp_mem_ram: synchronous RAM with 1 write port and 1 registered read port, read-first, no reset on the array.
- The FSM, address muxing and dump skid stay in icp_mem.

Test Plan:
- Load 0x11, 0x22, 0x33 (last on 0x33) with ready always seen → o_core_rst falls the cycle after the third handshake; length=3.
- RUN: core reads addr 1 → o_core_data=0x22 next cycle. Core writes 0xAB to addr 1 and reads addr 1 in the same cycle → read returns 0x22, and a later read returns 0xAB.
- RUN: core writes addr DEPTH (4096) and reads addr 0x8000_0000 → o_fault=1, read data 0, mem[0] unchanged.
- Pulse i_stop; dump with i_dump_ready=1 → o_core_rst=1 the next cycle; words 0x11, 0xAB, 0x33 on consecutive cycles; o_dump_last on 0x33; then o_done=1.
- Dump with i_dump_ready toggling 1,0,0,1,… → data and last stay stable during stalls, with no word lost or duplicated.
- Load DEPTH words with i_load_last never set → RUN entered after word 4095. Assert i_rst mid-DUMP → state LOAD and all outputs at reset values next cycle.
